// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: default accumulator
// geometry, sweep state encoding and a small state classification helper.
package nco_pkg;

    // Default NCO step word geometry (integer.fraction)
    localparam int ACC_FRAC_WIDTH_DEF = 24;
    localparam int ACC_INT_WIDTH_DEF  = 8;
    localparam int DWELL_WIDTH_DEF    = 16;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2,
        ST_FINISH     = 2'd3
    } sweep_state_t;

    // True while a sweep is actively emitting steps
    function automatic logic is_sweeping(input sweep_state_t st);
        return (st == ST_SWEEP_UP) || (st == ST_SWEEP_DOWN);
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: loaded with the hold length D when a step is emitted, counts
// down once per cycle and flags the last cycle of the dwell so the controller
// can emit the next step exactly D cycles after the previous one.
module sweep_dwell_timer
    import nco_pkg::*;
#(
    parameter int WIDTH = DWELL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Down-counter: load wins over counting, saturates at zero when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != CNT_ZERO) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The cycle holding a count of one is the final cycle of the dwell
    assign expire = (count_r == CNT_ONE);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep controller. Walks the NCO step word from start_step to
// stop_step (optionally back down, optionally repeating), holding each value
// for a programmable number of cycles and pulsing nco_step_enable whenever the
// step word changes. Configuration is captured when a sweep is accepted.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_FRAC_WIDTH = ACC_FRAC_WIDTH_DEF,
    parameter int ACC_INT_WIDTH  = ACC_INT_WIDTH_DEF,
    parameter int DWELL_WIDTH    = DWELL_WIDTH_DEF
) (
    input  logic                                    aclk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [ACC_INT_WIDTH+ACC_FRAC_WIDTH-1:0] start_step,
    input  logic [ACC_INT_WIDTH+ACC_FRAC_WIDTH-1:0] stop_step,
    input  logic [ACC_INT_WIDTH+ACC_FRAC_WIDTH-1:0] step_inc,
    input  logic [DWELL_WIDTH-1:0]                  dwell_cycles,
    input  logic                                    bidir,
    input  logic                                    loop,
    output logic [ACC_INT_WIDTH+ACC_FRAC_WIDTH-1:0] nco_step,
    output logic                                    nco_step_enable,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    cfg_err
);

    localparam int SW = ACC_INT_WIDTH + ACC_FRAC_WIDTH;

    localparam logic [SW-1:0]          STEP_ZERO  = {SW{1'b0}};
    localparam logic [DWELL_WIDTH-1:0] DWELL_ZERO = {DWELL_WIDTH{1'b0}};
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    // Latched sweep configuration
    sweep_state_t           state_r;
    logic [SW-1:0]          start_r;
    logic [SW-1:0]          stop_r;
    logic [SW-1:0]          inc_r;
    logic [DWELL_WIDTH-1:0] dwell_r;
    logic                   bidir_r;
    logic                   loop_r;

    // Step arithmetic and control decode
    logic [SW:0]            sum_s;
    logic [SW:0]            diff_s;
    logic [SW-1:0]          up_next_s;
    logic [SW-1:0]          down_next_s;
    logic                   at_stop_s;
    logic                   at_start_s;
    logic                   single_s;
    logic                   cfg_ok_s;
    logic [DWELL_WIDTH-1:0] dwell_eff_s;
    logic                   accept_s;
    logic                   advance_s;
    logic                   last_s;
    logic                   timer_load_s;
    logic                   timer_clear_s;
    logic [DWELL_WIDTH-1:0] timer_value_s;
    logic                   expire_s;

    // Next-step arithmetic with clamping, plus decode of which events fire
    always_comb begin
        sum_s       = {1'b0, nco_step} + {1'b0, inc_r};
        diff_s      = {1'b0, nco_step} - {1'b0, inc_r};
        up_next_s   = stop_r;
        down_next_s = start_r;
        at_stop_s   = (nco_step == stop_r);
        at_start_s  = (nco_step == start_r);
        single_s    = (start_r == stop_r);
        cfg_ok_s    = (start_step <= stop_step) && (step_inc != STEP_ZERO);
        dwell_eff_s = dwell_cycles;
        last_s      = 1'b0;

        // Overshoot or carry out of the word pins the step to the upper bound
        if (sum_s[SW] || (sum_s[SW-1:0] >= stop_r)) begin
            up_next_s = stop_r;
        end else begin
            up_next_s = sum_s[SW-1:0];
        end

        // Undershoot or borrow pins the step to the lower bound
        if (diff_s[SW] || (diff_s[SW-1:0] <= start_r)) begin
            down_next_s = start_r;
        end else begin
            down_next_s = diff_s[SW-1:0];
        end

        // A zero dwell still holds each step for one cycle
        if (dwell_cycles == DWELL_ZERO) begin
            dwell_eff_s = DWELL_ONE;
        end else begin
            dwell_eff_s = dwell_cycles;
        end

        // Identify the dwell that ends the whole sweep
        case (state_r)
            ST_SWEEP_UP:   last_s = at_stop_s && !loop_r && (!bidir_r || single_s);
            ST_SWEEP_DOWN: last_s = at_start_s && !loop_r;
            default:       last_s = 1'b0;
        endcase

        accept_s      = (state_r == ST_IDLE) && start && !abort && cfg_ok_s;
        advance_s     = is_sweeping(state_r) && !abort && expire_s;
        timer_load_s  = accept_s || (advance_s && !last_s);
        timer_clear_s = abort && (state_r != ST_IDLE);

        if (state_r == ST_IDLE) begin
            timer_value_s = dwell_eff_s;
        end else begin
            timer_value_s = dwell_r;
        end
    end

    sweep_dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk        (aclk),
        .rst        (rst),
        .clear      (timer_clear_s),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .expire     (expire_s)
    );

    // Sweep state machine with registered step word and status pulses
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            start_r         <= STEP_ZERO;
            stop_r          <= STEP_ZERO;
            inc_r           <= STEP_ZERO;
            dwell_r         <= DWELL_ZERO;
            bidir_r         <= 1'b0;
            loop_r          <= 1'b0;
            nco_step        <= STEP_ZERO;
            nco_step_enable <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            nco_step_enable <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // Abort in the same cycle suppresses the request entirely
                    if (start && !abort) begin
                        if (cfg_ok_s) begin
                            start_r         <= start_step;
                            stop_r          <= stop_step;
                            inc_r           <= step_inc;
                            dwell_r         <= dwell_eff_s;
                            bidir_r         <= bidir;
                            loop_r          <= loop;
                            nco_step        <= start_step;
                            nco_step_enable <= 1'b1;
                            busy            <= 1'b1;
                            state_r         <= ST_SWEEP_UP;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_SWEEP_UP: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (expire_s) begin
                        if (!at_stop_s) begin
                            nco_step        <= up_next_s;
                            nco_step_enable <= 1'b1;
                        end else if (single_s) begin
                            // Degenerate range: one value, repeated only when looping
                            if (loop_r) begin
                                nco_step        <= start_r;
                                nco_step_enable <= 1'b1;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= ST_FINISH;
                            end
                        end else if (bidir_r) begin
                            nco_step        <= down_next_s;
                            nco_step_enable <= 1'b1;
                            state_r         <= ST_SWEEP_DOWN;
                        end else if (loop_r) begin
                            nco_step        <= start_r;
                            nco_step_enable <= 1'b1;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end else begin
                        state_r <= ST_SWEEP_UP;
                    end
                end

                ST_SWEEP_DOWN: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (expire_s) begin
                        if (!at_start_s) begin
                            nco_step        <= down_next_s;
                            nco_step_enable <= 1'b1;
                        end else if (loop_r) begin
                            // Lower bound already emitted; resume with the next up step
                            nco_step        <= up_next_s;
                            nco_step_enable <= 1'b1;
                            state_r         <= ST_SWEEP_UP;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end else begin
                        state_r <= ST_SWEEP_DOWN;
                    end
                end

                ST_FINISH: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl. The driver computes, for each sweep
// request, the full list of step values from the bounds/increment with plain
// integer arithmetic and schedules them on a timeline; a monitor on the
// falling edge pops and compares whenever the DUT should or does pulse.
module tb_nco_sweep_ctrl;

    logic        aclk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] start_step;
    logic [31:0] stop_step;
    logic [31:0] step_inc;
    logic [15:0] dwell_cycles;
    logic        bidir;
    logic        loop;
    logic [31:0] nco_step;
    logic        nco_step_enable;
    logic        busy;
    logic        done;
    logic        cfg_err;

    nco_sweep_ctrl dut (
        .aclk            (aclk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .start_step      (start_step),
        .stop_step       (stop_step),
        .step_inc        (step_inc),
        .dwell_cycles    (dwell_cycles),
        .bidir           (bidir),
        .loop            (loop),
        .nco_step        (nco_step),
        .nco_step_enable (nco_step_enable),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    typedef struct {
        longint      t;
        logic [31:0] val;
    } ev_t;

    ev_t         step_q[$];
    ev_t         done_q[$];
    ev_t         err_q[$];

    longint      cyc     = 0;
    longint      busy_lo = 0;
    longint      busy_hi = 0;
    longint      rst_at  = -1;
    logic [31:0] exp_step = 32'd0;
    int          errors  = 0;
    int          checks  = 0;
    bit          mon_en  = 1'b0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: schedule every step/done/cfg_err event of one request.
    // Events at or after 'cap' (abort or reset edge) are never produced.
    task automatic model_sweep(input longint s, input logic [31:0] ss, input logic [31:0] sp,
                               input logic [31:0] inc, input logic [15:0] dw,
                               input bit bd, input bit lp, input longint cap,
                               output longint t_end);
        longint a, b, c, d, v, t;
        longint up[$];
        longint dn[$];
        longint seq[$];
        ev_t    ev;
        a = longint'({32'd0, ss});
        b = longint'({32'd0, sp});
        c = longint'({32'd0, inc});
        d = (dw == 16'd0) ? 64'd1 : longint'({48'd0, dw});
        busy_lo = s;
        if (a > b || c == 0) begin
            ev.t = s; ev.val = 32'd0;
            if (s < cap) err_q.push_back(ev);
            busy_hi = s;
            t_end = s;
            return;
        end
        v = a; up.push_back(v);
        while (v < b) begin v = v + c; if (v > b) v = b; up.push_back(v); end
        v = b;
        while (v > a) begin v = v - c; if (v < a) v = a; dn.push_back(v); end
        t = s;
        for (int pass = 0; ; pass++) begin
            seq.delete();
            foreach (up[i]) if (!(pass > 0 && bd && a != b && i == 0)) seq.push_back(up[i]);
            if (bd && a != b) foreach (dn[i]) seq.push_back(dn[i]);
            foreach (seq[i]) begin
                v = seq[i];
                ev.t = t; ev.val = v[31:0];
                if (t < cap) step_q.push_back(ev);
                t = t + d;
            end
            if (!lp || t >= cap) break;
        end
        if (!lp) begin
            ev.t = t; ev.val = 32'd0;
            if (t < cap) done_q.push_back(ev);
            busy_hi = (t < cap) ? t : cap;
            t_end = t;
        end else begin
            busy_hi = cap;
            t_end = cap;
        end
    endtask

    // Issue one sweep request; intr_after >= 0 interrupts it (abort or reset)
    // that many edges after the start edge. Config inputs are scrambled while
    // it runs and stray start pulses are issued while it should be busy.
    task automatic run(input logic [31:0] ss, input logic [31:0] sp, input logic [31:0] inc,
                       input logic [15:0] dw, input bit bd, input bit lp,
                       input int intr_after, input bit use_rst);
        longint s, cap, t_end, stop_at;
        @(posedge aclk); #1;
        start_step = ss; stop_step = sp; step_inc = inc; dwell_cycles = dw;
        bidir = bd; loop = lp; start = 1'b1; abort = 1'b0;
        s = cyc + 1;
        cap = (intr_after >= 0) ? s + intr_after : 64'h7fff_ffff_ffff;
        model_sweep(s, ss, sp, inc, dw, bd, lp, cap, t_end);
        if (use_rst && intr_after >= 0) rst_at = cap;
        stop_at = (intr_after >= 0) ? cap + 2 : t_end + 2;
        while (cyc < stop_at) begin
            @(posedge aclk); #1;
            start        = (cyc + 1 < busy_hi) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_step   = $urandom;
            stop_step    = $urandom;
            step_inc     = $urandom;
            dwell_cycles = 16'($urandom);
            bidir        = 1'($urandom_range(0, 1));
            loop         = 1'($urandom_range(0, 1));
            abort        = !use_rst && intr_after >= 0 && (cyc + 1 == cap);
            rst          = use_rst && intr_after >= 0 && (cyc + 1 == cap);
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    // Monitor: compare pulses, step word and busy against the scheduled timeline
    always @(negedge aclk) begin : monitor
        ev_t ev;
        bit  exp_pulse;
        if (mon_en) begin
            if (cyc == rst_at) exp_step = 32'd0;

            exp_pulse = (step_q.size() > 0) && (step_q[0].t == cyc);
            check("enable_pulse", {31'd0, nco_step_enable}, {31'd0, exp_pulse});
            if (exp_pulse) begin
                ev = step_q.pop_front();
                check("step_value", nco_step, ev.val);
                exp_step = ev.val;
            end

            exp_pulse = (done_q.size() > 0) && (done_q[0].t == cyc);
            check("done_pulse", {31'd0, done}, {31'd0, exp_pulse});
            if (exp_pulse) ev = done_q.pop_front();

            exp_pulse = (err_q.size() > 0) && (err_q[0].t == cyc);
            check("cfg_err_pulse", {31'd0, cfg_err}, {31'd0, exp_pulse});
            if (exp_pulse) ev = err_q.pop_front();

            check("step_hold", nco_step, exp_step);
            check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc < busy_hi)});
        end
    end

    initial begin
        logic [31:0] base, span, ss, sp, inc;
        logic [15:0] dw;
        bit          bd, lp;
        int          intr, kind;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_step = 32'd0; stop_step = 32'd0; step_inc = 32'd0;
        dwell_cycles = 16'd0; bidir = 1'b0; loop = 1'b0;
        repeat (2) @(posedge aclk);
        #1 mon_en = 1'b1;
        repeat (3) @(posedge aclk);
        #1 rst = 1'b0;

        // Directed cases
        run(32'd100, 32'd400, 32'd100, 16'd3, 1'b0, 1'b0, -1, 1'b0);
        run(32'd100, 32'd350, 32'd100, 16'd1, 1'b1, 1'b0, -1, 1'b0);
        run(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd2, 1'b0, 1'b0, -1, 1'b0);
        run(32'd500, 32'd100, 32'd100, 16'd2, 1'b0, 1'b0, -1, 1'b0);
        run(32'd100, 32'd400, 32'd0, 16'd2, 1'b0, 1'b0, -1, 1'b0);
        run(32'd100, 32'd400, 32'd100, 16'd4, 1'b1, 1'b1, 23, 1'b0);
        run(32'd200, 32'd200, 32'd7, 16'd0, 1'b1, 1'b0, -1, 1'b0);
        run(32'd200, 32'd200, 32'd7, 16'd2, 1'b0, 1'b1, 17, 1'b0);
        run(32'd0, 32'd1000, 32'd300, 16'd2, 1'b1, 1'b0, -1, 1'b0);
        run(32'd100, 32'd400, 32'd100, 16'd3, 1'b0, 1'b0, 7, 1'b1);
        run(32'd10, 32'd95, 32'd20, 16'd1, 1'b1, 1'b1, 30, 1'b0);

        // Start and abort together in IDLE: nothing may happen
        @(posedge aclk); #1;
        start_step = 32'd1; stop_step = 32'd9; step_inc = 32'd1; dwell_cycles = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (4) @(posedge aclk);

        // Randomized requests
        for (int k = 0; k < 30; k++) begin
            base = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1000))
                                                : 32'hFFFF_F000 + 32'($urandom_range(0, 2048));
            span = 32'($urandom_range(0, 2047));
            ss   = base;
            sp   = base + span;
            inc  = 32'($urandom_range(span / 8 + 1, span + 256));
            dw   = 16'($urandom_range(0, 3));
            bd   = 1'($urandom_range(0, 1));
            lp   = ($urandom_range(0, 3) == 0);
            intr = lp ? int'($urandom_range(5, 60)) : -1;
            kind = int'($urandom_range(0, 7));
            if (kind == 0) inc = 32'd0;
            if (kind == 1 && span != 32'd0) begin ss = sp; sp = base; end
            if (kind == 2 && !lp) intr = int'($urandom_range(2, 15));
            run(ss, sp, inc, dw, bd, lp, intr, 1'b0);
        end

        repeat (4) @(posedge aclk);
        #1;
        check("queue_drained", 32'(step_q.size() + done_q.size() + err_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
